// File: rtl/xy_pair_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | xy_pair_detect                                                           |
// | I/Q detector: windowed accumulation of adc*cos / adc*sin, scaled,        |
// | saturated to 18 bits and emitted as an interleaved X/Y pair stream.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module xy_pair_detect #(
    parameter int ACC_W = 48,
    parameter int SHIFT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] adc,
    input  logic signed [15:0] lo_cos,
    input  logic signed [15:0] lo_sin,
    input  logic               in_valid,
    input  logic [11:0]        win_len,
    output logic signed [17:0] out_d,
    output logic               out_strobe
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EMIT_X = 2'd1;
    localparam logic [1:0] ST_EMIT_Y = 2'd2;

    localparam logic signed [17:0] C_SAT_POS = 18'sh1FFFF;
    localparam logic signed [17:0] C_SAT_NEG = 18'sh20000;

    logic [11:0]              r_cnt;
    logic [11:0]              r_wl;
    logic [11:0]              w_wl_now;
    logic                     w_last_now;
    logic signed [31:0]       r_pc;
    logic signed [31:0]       r_ps;
    logic                     r_v1;
    logic                     r_l1;
    logic signed [ACC_W-1:0]  w_pc_ext;
    logic signed [ACC_W-1:0]  w_ps_ext;
    logic signed [ACC_W-1:0]  r_acc_x;
    logic signed [ACC_W-1:0]  r_acc_y;
    logic signed [ACC_W-1:0]  r_dump_x;
    logic signed [ACC_W-1:0]  r_dump_y;
    logic                     r_dump_go;
    logic signed [17:0]       w_sat_x;
    logic signed [17:0]       w_sat_y;
    logic [1:0]               r_state;

    // The first sample of a window sees win_len directly; later samples use the latched copy.
    always_comb begin
        w_wl_now = r_wl;
        if (r_cnt == 12'd0) begin
            w_wl_now = (win_len < 12'd2) ? 12'd2 : win_len;
        end
        w_last_now = (r_cnt == (w_wl_now - 12'd1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_wl  <= 12'd2;
            r_pc  <= '0;
            r_ps  <= '0;
            r_v1  <= 1'b0;
            r_l1  <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            r_l1 <= in_valid & w_last_now;
            if (in_valid) begin
                r_pc <= adc * lo_cos;
                r_ps <= adc * lo_sin;
                if (r_cnt == 12'd0) begin
                    r_wl <= w_wl_now;
                end
                r_cnt <= w_last_now ? 12'd0 : r_cnt + 12'd1;
            end
        end
    end

    assign w_pc_ext = {{(ACC_W-32){r_pc[31]}}, r_pc};
    assign w_ps_ext = {{(ACC_W-32){r_ps[31]}}, r_ps};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_x   <= '0;
            r_acc_y   <= '0;
            r_dump_x  <= '0;
            r_dump_y  <= '0;
            r_dump_go <= 1'b0;
        end else begin
            r_dump_go <= r_v1 & r_l1;
            if (r_v1) begin
                if (r_l1) begin
                    r_dump_x <= r_acc_x + w_pc_ext;
                    r_dump_y <= r_acc_y + w_ps_ext;
                    r_acc_x  <= '0;
                    r_acc_y  <= '0;
                end else begin
                    r_acc_x  <= r_acc_x + w_pc_ext;
                    r_acc_y  <= r_acc_y + w_ps_ext;
                end
            end
        end
    end

    function automatic logic signed [17:0] sat18(input logic signed [ACC_W-1:0] d);
        logic signed [ACC_W-1:0] sx;
        sx = d >>> SHIFT;
        if ((&sx[ACC_W-1:17]) || !(|sx[ACC_W-1:17])) begin
            return sx[17:0];
        end
        return d[ACC_W-1] ? C_SAT_NEG : C_SAT_POS;
    endfunction

    assign w_sat_x = sat18(r_dump_x);
    assign w_sat_y = sat18(r_dump_y);

    // Dumps are at least two cycles apart, so dump_y is still intact when Y is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            out_d      <= '0;
            out_strobe <= 1'b0;
        end else begin
            case (r_state)
                ST_EMIT_X: begin
                    r_state    <= ST_EMIT_Y;
                    out_d      <= w_sat_y;
                    out_strobe <= 1'b0;
                end
                default: begin
                    if (r_dump_go) begin
                        r_state    <= ST_EMIT_X;
                        out_d      <= w_sat_x;
                        out_strobe <= 1'b1;
                    end else begin
                        r_state    <= ST_IDLE;
                        out_d      <= '0;
                        out_strobe <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/xy_pair_detect.md
Name: xy_pair_detect

Overview:
- Synchronous I/Q detector that produces the interleaved X/Y pair stream consumed by the PI gain stage.
- Multiplies each ADC sample by local-oscillator cos/sin and accumulates both products over a programmable window.
- At window end, emits X then Y, one per cycle, with out_strobe high on the X cycle only.
- Sits between the ADC/LO front end and the feedback controller.

Parameters:
- ACC_W, 48, accumulator width in bits; must be at least 32 + log2(max window) + 1.
- SHIFT, 16, right-shift applied to each accumulated sum before saturation to 18 bits.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- adc  input  16  signed ADC sample.
- lo_cos  input  16  signed LO cosine, aligned with adc.
- lo_sin  input  16  signed LO sine, aligned with adc.
- in_valid  input  1  adc, lo_cos and lo_sin are valid this cycle.
- win_len  input  12  samples per window; values 0..1 are treated as 2.
- out_d  output  18  signed pair stream: X on the strobe cycle, Y on the next cycle, 0 otherwise.
- out_strobe  output  1  high for exactly one cycle, coincident with X.

Behaviour:
- One clock; reset is synchronous and active-high (rst sampled on posedge clk).
- Reset clears: product registers, both accumulators, sample counter, dump registers, emitter state; out_d=0, out_strobe=0.
- Reset mid-window discards the partial window. Reset during EMIT_Y suppresses the Y output.
- Stage 1 (product registers):
  - On in_valid, register pc=adc*lo_cos and ps=adc*lo_sin (signed 32-bit).
  - Register the valid flag v1 and last flag l1.
  - l1 is high when this sample is the window's final sample, i.e. counter == wl-1.
- wl: the window length, latched from win_len when counter==0 and in_valid. Changing win_len mid-window has no effect until the next window.
- Sample counter: increments on each in_valid and wraps to 0 after wl-1.
- Stage 2 (accumulate), on v1:
  - acc_x += sign-extended pc; acc_y += sign-extended ps.
  - If l1: load dump_x = acc_x+pc and dump_y = acc_y+ps, clear both accumulators to 0 in the same cycle, and assert dump_go.
  - The next window accumulates without a gap; no sample is lost or double-counted.
- Scaling:
  - sx = dump_x >>> SHIFT (arithmetic).
  - If sx fits in 18-bit signed range, pass it through; else saturate to +131071 or -131072 according to the sign of dump_x.
  - Same rule for Y.
- Emitter FSM:
  - IDLE: on dump_go -> EMIT_X.
  - EMIT_X (one cycle): out_d=sat(X), out_strobe=1 -> EMIT_Y.
  - EMIT_Y (one cycle): out_d=sat(Y), out_strobe=0 -> IDLE. If dump_go is asserted in this same cycle, go to EMIT_X instead.
  - out_d and out_strobe are registered outputs.
- Latency: last sample of a window accepted at cycle t -> X on out_d at t+3 (out_strobe=1) -> Y at t+4.
- Minimum window of 2 with contiguous in_valid yields back-to-back pairs, strobe every 2nd cycle; the emitter can never be overrun.
- Gaps in in_valid stretch the window; the count is in valid samples, not cycles.

Test Plan:
- Basic window: rst pulse; win_len=4, SHIFT=16; 4 contiguous samples adc=1000, cos=16384, sin=0 -> one pair: out_strobe=1 with out_d=1000, next cycle out_d=0, exactly 3 cycles after the last sample.
- Quadrature sign: adc=-1000, cos=0, sin=16384, win_len=4 -> X=0 (strobe), Y=-1000.
- Back-to-back windows: win_len=2, in_valid continuous for 8 samples with adc=1000, cos=sin=16384, pairs expected X=Y=500 -> strobe exactly every other cycle, 4 pairs each X=500 and Y=500, no dropped sample.
- Saturation, positive: adc=32767, cos=32767, win_len=4095 -> X=131071. Negative: adc=32767, cos=-32768 -> X=-131072.
- Mid-window changes: win_len changed 4->8 after sample 2 -> first window still closes after 4 samples, the next after 8. Separately, in_valid gaps of 3 cycles between samples -> same X as contiguous, later in time.
- Reset handling: rst after 2 of 4 samples -> no output; next full 4-sample window reports only its own samples. rst asserted on the X cycle -> Y never appears and out_d=0 the following cycle.
